// File: rtl/zbb_iter_unit.sv
// zbb_iter_unit: multi-cycle Zbb unit (andn/orn/xnor, min/max, clz/ctz/cpop)
// Bit counts scan STEP bits per BUSY cycle with a data-independent latency.
module zbb_iter_unit #(
   parameter int XLEN = 32,
   parameter int STEP = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_illegal
);
   localparam int NS = XLEN / STEP;
   localparam int CW = $clog2(XLEN + 1);
   localparam int IW = $clog2(NS + 1);
   localparam logic [IW-1:0] LAST = IW'(NS - 1);
   localparam logic [3:0] OP_ANDN = 4'd0, OP_ORN = 4'd1, OP_XNOR = 4'd2, OP_CLZ = 4'd3,
      OP_CTZ = 4'd4, OP_CPOP = 4'd5, OP_MIN = 4'd6, OP_MAX = 4'd7, OP_MINU = 4'd8, OP_MAXU = 4'd9;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, res_q, res_d, alu_res, slice_full;
   logic [STEP-1:0]   slice;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_nx, zc, pc;
   logic [IW-1:0]     iter_q, iter_d;
   logic              found_q, found_d, ill_q, ill_d, hit, lt_s, lt_u, is_cnt;

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_result  = res_q;
   assign out_illegal = ill_q;
   assign lt_s        = $signed(in_rs1) < $signed(in_rs2);
   assign lt_u        = in_rs1 < in_rs2;
   assign is_cnt      = (in_op == OP_CLZ) || (in_op == OP_CTZ) || (in_op == OP_CPOP);

   always_comb begin
      case (in_op)
         OP_ANDN: alu_res = in_rs1 & ~in_rs2;
         OP_ORN:  alu_res = in_rs1 | ~in_rs2;
         OP_XNOR: alu_res = ~(in_rs1 ^ in_rs2);
         OP_MIN:  alu_res = (lt_s || in_rs1 == in_rs2) ? in_rs1 : in_rs2;
         OP_MAX:  alu_res = (!lt_s) ? in_rs1 : in_rs2;
         OP_MINU: alu_res = (lt_u || in_rs1 == in_rs2) ? in_rs1 : in_rs2;
         OP_MAXU: alu_res = (!lt_u) ? in_rs1 : in_rs2;
         default: alu_res = '0;
      endcase
   end

   // CLZ consumes the operand from the top, CTZ/CPOP from the bottom
   assign slice_full = (op_q == OP_CLZ) ? (a_q >> (XLEN - STEP)) : a_q;
   assign slice      = slice_full[STEP-1:0];

   always_comb begin
      hit = 1'b0;
      zc  = '0;
      pc  = '0;
      for (int i = 0; i < STEP; i++) begin
         pc = pc + CW'(slice[i]);
         if ((op_q == OP_CLZ) ? slice[STEP-1-i] : slice[i]) hit = 1'b1;
         else if (!hit) zc = zc + CW'(1);
      end
      cnt_nx = cnt_q + ((op_q == OP_CPOP) ? pc : (found_q ? '0 : zc));
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      iter_d  = iter_q;
      found_d = found_q;
      res_d   = res_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: if (in_valid) begin
            op_d    = in_op;
            a_d     = in_rs1;
            cnt_d   = '0;
            iter_d  = '0;
            found_d = 1'b0;
            if (is_cnt) state_d = BUSY;
            else begin
               state_d = DONE;
               res_d   = alu_res;
               ill_d   = (in_op > OP_MAXU);
            end
         end
         BUSY: begin
            a_d     = (op_q == OP_CLZ) ? (a_q << STEP) : (a_q >> STEP);
            cnt_d   = cnt_nx;
            found_d = found_q | hit;
            iter_d  = iter_q + IW'(1);
            if (iter_q == LAST) begin
               state_d = DONE;
               res_d   = XLEN'(cnt_nx);
               ill_d   = 1'b0;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         iter_q  <= '0;
         found_q <= 1'b0;
         res_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         found_q <= found_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
      end
   end
endmodule

// File: tb/tb_zbb_iter_unit.sv
// tb_zbb_iter_unit: directed checks of zbb_iter_unit at 32/4 and 64/8.
module tb_zbb_iter_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [3:0]  in_op = '0;
   logic [31:0] in_rs1 = '0, in_rs2 = '0, out_result;
   logic        in_ready, out_valid, out_illegal;
   logic        v64 = 1'b0, r64 = 1'b0, in_ready64, out_valid64, out_illegal64;
   logic [3:0]  op64 = '0;
   logic [63:0] a64 = '0, out_result64;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   zbb_iter_unit #(.XLEN(32), .STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_illegal(out_illegal));

   zbb_iter_unit #(.XLEN(64), .STEP(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(in_ready64), .in_op(op64),
      .in_rs1(a64), .in_rs2(64'd0), .flush(1'b0), .out_valid(out_valid64),
      .out_ready(r64), .out_result(out_result64), .out_illegal(out_illegal64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                        input logic ill, input int hold);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_op = 4'($urandom); in_rs1 = $urandom; in_rs2 = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
      chk({tag, " result"}, 64'(out_result), 64'(exp));
      chk({tag, " illegal"}, 64'(out_illegal), 64'(ill));
      chk({tag, " busy_ready"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, " hold_result"}, 64'(out_result), 64'(exp));
         chk({tag, " hold_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " idle_ready"}, 64'(in_ready), 64'd1);
      chk({tag, " idle_valid"}, 64'(out_valid), 64'd0);
      chk({tag, " idle_result"}, 64'(out_result), 64'(exp));
   endtask

   task automatic run64(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] exp);
      int lat;
      @(negedge clk);
      v64 = 1'b1; op64 = op; a64 = a;
      @(posedge clk);
      @(negedge clk);
      v64 = 1'b0; a64 = {$urandom, $urandom};
      lat = 1;
      while (!out_valid64 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd9);
      chk({tag, " result"}, out_result64, exp);
      chk({tag, " illegal"}, 64'(out_illegal64), 64'd0);
      r64 = 1'b1;
      @(negedge clk);
      r64 = 1'b0;
      chk({tag, " idle_ready"}, 64'(in_ready64), 64'd1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst ready", 64'(in_ready), 64'd1);
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst result", 64'(out_result), 64'd0);
      chk("rst illegal", 64'(out_illegal), 64'd0);
      chk("rst ready64", 64'(in_ready64), 64'd1);

      run32("andn", 4'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1, 1'b0, 0);
      run32("orn",  4'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_F0F0, 1, 1'b0, 0);
      run32("xnor", 4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_F0F0, 1, 1'b0, 0);
      run32("min",  4'd6, 32'h8000_0000, 32'd1, 32'h8000_0000, 1, 1'b0, 0);
      run32("max",  4'd7, 32'h8000_0000, 32'd1, 32'd1, 1, 1'b0, 0);
      run32("minu", 4'd8, 32'h8000_0000, 32'd1, 32'd1, 1, 1'b0, 0);
      run32("maxu", 4'd9, 32'h8000_0000, 32'd1, 32'h8000_0000, 1, 1'b0, 0);
      run32("min_eq", 4'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0005, 1, 1'b0, 0);
      run32("clz",  4'd3, 32'h0001_0000, 32'd0, 32'd15, 9, 1'b0, 0);
      run32("ctz",  4'd4, 32'h0001_0000, 32'd0, 32'd16, 9, 1'b0, 0);
      run32("cpop", 4'd5, 32'hF0F0_F0F0, 32'd0, 32'd16, 9, 1'b0, 0);
      run32("clz0", 4'd3, 32'd0, 32'd0, 32'd32, 9, 1'b0, 0);
      run32("ctz0", 4'd4, 32'd0, 32'd0, 32'd32, 9, 1'b0, 0);
      run32("clz_msb", 4'd3, 32'h8000_0000, 32'd0, 32'd0, 9, 1'b0, 0);
      run32("ctz_msb", 4'd4, 32'h8000_0000, 32'd0, 32'd31, 9, 1'b0, 0);
      run32("clz_mid", 4'd3, 32'h0000_0101, 32'd0, 32'd23, 9, 1'b0, 0);
      run32("illegal", 4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1, 1'b1, 0);
      run32("after_ill", 4'd0, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1, 1'b0, 0);
      run32("backpress", 4'd5, 32'h0000_0007, 32'd0, 32'd3, 9, 1'b0, 5);

      // flush during the third BUSY cycle
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd5; in_rs1 = 32'h0000_00FF;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("flush busy", 64'(in_ready), 64'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush ready", 64'(in_ready), 64'd1);
      chk("flush valid", 64'(out_valid), 64'd0);
      repeat (10) @(negedge clk);
      chk("flush no_valid", 64'(out_valid), 64'd0);
      chk("flush result", 64'(out_result), 64'd3);

      // flush wins over a simultaneous accept
      in_valid = 1'b1; in_op = 4'd0; in_rs1 = 32'hFFFF_FFFF; in_rs2 = 32'd0; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_acc ready", 64'(in_ready), 64'd1);
      chk("flush_acc valid", 64'(out_valid), 64'd0);
      run32("cpop_ones", 4'd5, 32'hFFFF_FFFF, 32'd0, 32'd32, 9, 1'b0, 0);

      // reset held two cycles in the middle of BUSY
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd3; in_rs1 = 32'h0000_0001;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid ready", 64'(in_ready), 64'd1);
      chk("rst_mid valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid result", 64'(out_result), 64'd0);
      chk("rst_mid illegal", 64'(out_illegal), 64'd0);
      repeat (12) @(negedge clk);
      chk("rst_mid no_valid", 64'(out_valid), 64'd0);

      run64("clz64", 4'd3, 64'd1, 64'd63);
      run64("ctz64", 4'd4, 64'h8000_0000_0000_0000, 64'd63);
      run64("cpop64", 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64);
      run64("clz64_0", 4'd3, 64'd0, 64'd64);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
